seq_stepper: RTL and testbench
==============================

Name: seq_stepper

Overview:
- Parametrised multi-stage timed sequencer, successor to the fixed five-state dwell sequencer.
- Steps through N_STAGE stages. Each stage lasts a programmable number of enabled cycles and drives a programmable N_CH-channel output word.
- Adds a runtime-loadable configuration table, start/stop control, a one-shot or loop mode, and status outputs.
- Sits between control logic and output drivers, e.g. an LED/phase pattern generator.

Parameters:
- N_STAGE, 5, number of stages (2..16).
- CNT_W, 4, dwell counter width; max dwell 2^CNT_W-1.
- DOUT_W, 2, bits per output channel.
- N_CH, 2, number of output channels.
- ST_W, derived $clog2(N_STAGE), stage index width (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- en  in  1  count enable; the dwell counter advances only when high.
- start  in  1  pulse; begin or restart the sequence at stage 0.
- stop  in  1  pulse; abort to IDLE.
- mode_loop  in  1  1: wrap from the last stage to stage 0; 0: one-shot.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  ST_W  stage index to write.
- cfg_dwell  in  CNT_W  dwell cycles for that stage.
- cfg_dout  in  N_CH*DOUT_W  output word for that stage; channel k is at bits [k*DOUT_W +: DOUT_W].
- dout  out  N_CH*DOUT_W  registered output word.
- stage  out  ST_W  current stage index.
- busy  out  1  high while in RUN.
- stage_adv  out  1  one-cycle pulse on every stage transition.
- done  out  1  one-cycle pulse when a one-shot sequence completes.

Behaviour:
- Reset values:
  - state=IDLE, stage=0, cnt=0, dout=0, busy=0, stage_adv=0, done=0.
  - dwell table: every entry =1.
  - dout table: every entry =0.
- Controller states are IDLE and RUN. The stage index is a separate register.
- Dwell count:
  - Effective dwell d = (table value==0) ? 1 : table value.
  - end_cnt = en && state==RUN && cnt >= d-1. Using >= guards against a dwell being shortened below the current cnt.
  - cnt increments on en in RUN and clears to 0 on end_cnt. It holds while en=0 and clears on entering IDLE.
- Transitions:
  - IDLE: start -> RUN with stage=0, cnt=0.
  - RUN, end_cnt, stage<N_STAGE-1: stage+1, stage_adv=1.
  - RUN, end_cnt, stage==N_STAGE-1, mode_loop=1: stage=0, stage_adv=1, stay in RUN.
  - RUN, end_cnt, stage==N_STAGE-1, mode_loop=0: go to IDLE, stage=0, done=1, stage_adv=0.
  - RUN, start: restart at stage=0, cnt=0. No done pulse; stage_adv=1 only if stage was nonzero.
  - stop in any state: go to IDLE, stage=0, cnt=0. stop takes priority over start and end_cnt in the same cycle.
- mode_loop is sampled only at the last-stage end_cnt and may change at any time.
- Output latency:
  - dout is registered from the current state: dout <= (state==RUN) ? table[stage] : 0.
  - dout therefore trails stage/busy by one cycle, the same convention as the predecessor block.
  - busy and stage are register outputs taken directly from the controller.
- Configuration writes:
  - Accepted in any state and visible from the next cycle.
  - A write with cfg_addr >= N_STAGE is ignored.
  - A write during RUN to the active stage affects the current dwell and output immediately from the next cycle.
- Reset mid-run: all registers return to reset values asynchronously, including the tables.

Decomposition:
- Package seq_stepper_pkg holds:
  - state enum/constants: ST_IDLE=0, ST_RUN=1.
  - helper function for effective dwell (zero maps to one).
- One natural sub-module, seq_stepper_cfg: the configuration register file for the dwell and dout tables, with the write port and combinational read by stage.
- The controller, counter and output register stay in the top level.

Test Plan:
- Reset, then write dwell={1,2,2,2,3} and dout={0x0,0x5,0x9,0xA,0xF}; start with en=1, mode_loop=0 -> stage sequence 0,1,1,2,2,3,3,4,4,4. dout follows one cycle later. done pulses once after 10 RUN cycles; busy then falls.
- Same configuration with mode_loop=1 -> stage wraps 4->0 with stage_adv=1 and no done. Run three full periods of 10 cycles each.
- en toggled 1,0,1,0 during a dwell-3 stage -> cnt holds while en=0, so the stage lasts 3 enabled cycles (6 clocks).
- Assert stop and start in the same cycle mid-stage-2 -> IDLE, stage=0, dout=0 next cycle. Then start alone -> stage 0 restart.
- Write dwell 0 to stage 1, and write cfg_addr=N_STAGE with dwell 7 -> stage 1 lasts 1 cycle. The out-of-range write has no effect.
- Assert rst for one cycle mid-stage-3 -> all outputs 0 immediately, and the tables read back their defaults (stage 0 dwell 1 on the next start).

Source files
------------

// File: rtl/seq_stepper_pkg.sv
// Shared types and helpers for the multi-stage timed sequencer.
package seq_stepper_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest dwell counter the helper below handles.
  localparam int MAX_CNT_W = 16;

  // A programmed dwell of zero behaves as a one-cycle dwell.
  function automatic logic [MAX_CNT_W-1:0] eff_dwell(input logic [MAX_CNT_W-1:0] v);
    return (v == '0) ? MAX_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/seq_stepper_cfg.sv
// Configuration register file: per-stage dwell and output word, one write
// port, combinational read of the entry for the current stage.
module seq_stepper_cfg
  import seq_stepper_pkg::*;
#(
  parameter int N_STAGE = 5,
  parameter int CNT_W   = 4,
  parameter int DW      = 4,
  parameter int ST_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ST_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic [DW-1:0]    cfg_dout,
  input  logic [ST_W-1:0]  rd_stage,
  output logic [CNT_W-1:0] rd_dwell,
  output logic [DW-1:0]    rd_dout
);

  logic [CNT_W-1:0] dwell_q [N_STAGE];
  logic [DW-1:0]    dout_q  [N_STAGE];

  // Table storage; addresses beyond the last stage are silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STAGE; i++) begin
        dwell_q[i] <= CNT_W'(1);
        dout_q[i]  <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < N_STAGE)) begin
      dwell_q[cfg_addr] <= cfg_dwell;
      dout_q[cfg_addr]  <= cfg_dout;
    end
  end

  assign rd_dwell = dwell_q[rd_stage];
  assign rd_dout  = dout_q[rd_stage];

endmodule

// File: rtl/seq_stepper.sv
// Multi-stage timed sequencer. Each stage holds for a programmable number of
// enabled cycles and drives a programmable output word. busy is the
// controller state (1 = RUN); dout trails stage/busy by one cycle.
module seq_stepper
  import seq_stepper_pkg::*;
#(
  parameter  int N_STAGE = 5,
  parameter  int CNT_W   = 4,
  parameter  int DOUT_W  = 2,
  parameter  int N_CH    = 2,
  localparam int ST_W    = $clog2(N_STAGE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode_loop,
  input  logic                   cfg_we,
  input  logic [ST_W-1:0]        cfg_addr,
  input  logic [CNT_W-1:0]       cfg_dwell,
  input  logic [N_CH*DOUT_W-1:0] cfg_dout,
  output logic [N_CH*DOUT_W-1:0] dout,
  output logic [ST_W-1:0]        stage,
  output logic                   busy,
  output logic                   stage_adv,
  output logic                   done
);

  localparam int DW = N_CH * DOUT_W;

  state_t           state_q, state_d;
  logic [ST_W-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv_q, adv_d;
  logic             done_q, done_d;
  logic [DW-1:0]    dout_q;

  logic [CNT_W-1:0] rd_dwell;
  logic [DW-1:0]    rd_dout;
  logic [CNT_W-1:0] dwell_eff;
  logic             end_cnt;

  seq_stepper_cfg #(
    .N_STAGE (N_STAGE),
    .CNT_W   (CNT_W),
    .DW      (DW),
    .ST_W    (ST_W)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_dwell (cfg_dwell),
    .cfg_dout  (cfg_dout),
    .rd_stage  (stage_q),
    .rd_dwell  (rd_dwell),
    .rd_dout   (rd_dout)
  );

  // >= rather than == so a dwell rewritten below the running count still ends.
  assign dwell_eff = CNT_W'(eff_dwell(MAX_CNT_W'(rd_dwell)));
  assign end_cnt   = en && (state_q == ST_RUN) && (cnt_q >= dwell_eff - CNT_W'(1));

  // Controller, stage index and dwell counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
      done_q  <= done_d;
    end
  end

  // Next state: stop beats start, start beats end of dwell.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stage_d = '0;
          cnt_d   = '0;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (start) begin
            stage_d = '0;
            cnt_d   = '0;
            adv_d   = (stage_q != '0);
          end else if (end_cnt) begin
            cnt_d = '0;
            if (int'(stage_q) < N_STAGE - 1) begin
              stage_d = stage_q + ST_W'(1);
              adv_d   = 1'b1;
            end else if (mode_loop) begin
              stage_d = '0;
              adv_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              stage_d = '0;
              done_d  = 1'b1;
            end
          end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          stage_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output word registered from the current state and stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= (state_q == ST_RUN) ? rd_dout : '0;
  end

  assign dout      = dout_q;
  assign stage     = stage_q;
  assign busy      = (state_q == ST_RUN);
  assign stage_adv = adv_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_stepper.sv
// Directed bench for seq_stepper: inputs driven and outputs sampled on the
// falling edge; expected stage sequences are hand-written into exp_q.
module tb_seq_stepper;

  localparam int N_STAGE = 5;
  localparam int CNT_W   = 4;
  localparam int DOUT_W  = 2;
  localparam int N_CH    = 2;
  localparam int ST_W    = 3;
  localparam int DW      = N_CH * DOUT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             start;
  logic             stop;
  logic             mode_loop;
  logic             cfg_we;
  logic [ST_W-1:0]  cfg_addr;
  logic [CNT_W-1:0] cfg_dwell;
  logic [DW-1:0]    cfg_dout;
  logic [DW-1:0]    dout;
  logic [ST_W-1:0]  stage;
  logic             busy;
  logic             stage_adv;
  logic             done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] tb_dout [N_STAGE];
  logic [7:0]    exp_q[$];

  seq_stepper dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .mode_loop (mode_loop),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_dwell (cfg_dwell),
    .cfg_dout  (cfg_dout),
    .dout      (dout),
    .stage     (stage),
    .busy      (busy),
    .stage_adv (stage_adv),
    .done      (done)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cfg_write(input int addr, input int dwell, input int word);
    cfg_we    = 1'b1;
    cfg_addr  = ST_W'(addr);
    cfg_dwell = CNT_W'(dwell);
    cfg_dout  = DW'(word);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Advance falling edges until stage==t (already there counts); bounded.
  task automatic wait_stage(input int t);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (int'(stage) == t) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check("wait_stage_timeout", 32'(stage), 32'(t));
  endtask

  // Pulse start and check n RUN cycles against exp_q; then either the
  // one-shot completion or a stop abort.
  task automatic run_seq(input int n, input bit oneshot);
    int prev = 0;
    int e;
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = int'(exp_q.pop_front());
      check("seq_stage", 32'(stage), 32'(e));
      check("seq_busy", 32'(busy), 32'd1);
      check("seq_adv", 32'(stage_adv), (k > 0 && e != prev) ? 32'd1 : 32'd0);
      check("seq_done", 32'(done), 32'd0);
      check("seq_dout", 32'(dout), (k == 0) ? 32'd0 : 32'(tb_dout[prev]));
      prev = e;
    end
    if (oneshot) begin
      @(negedge clk);
      check("end_done", 32'(done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_stage", 32'(stage), 32'd0);
      check("end_adv", 32'(stage_adv), 32'd0);
      check("end_dout_last", 32'(dout), 32'(tb_dout[prev]));
      @(negedge clk);
      check("end_done_clr", 32'(done), 32'd0);
      check("end_dout_zero", 32'(dout), 32'd0);
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_stage", 32'(stage), 32'd0);
      check("stop_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] seq_a [10];
    logic       pat [6];
    seq_a = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
    pat   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_dwell = '0; cfg_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_adv", 32'(stage_adv), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Configuration
    tb_dout = '{4'h0, 4'h5, 4'h9, 4'hA, 4'hF};
    cfg_write(0, 1, 'h0);
    cfg_write(1, 2, 'h5);
    cfg_write(2, 2, 'h9);
    cfg_write(3, 2, 'hA);
    cfg_write(4, 3, 'hF);

    // One-shot: 0,1,1,2,2,3,3,4,4,4 then done
    en = 1'b1;
    for (int i = 0; i < 10; i++) exp_q.push_back(seq_a[i]);
    run_seq(10, 1'b1);

    // Loop mode: three full periods, wrap 4->0 with stage_adv, no done
    mode_loop = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 10; i++) exp_q.push_back(seq_a[i]);
    run_seq(30, 1'b0);
    mode_loop = 1'b0;

    // Enable gating during the dwell-3 stage
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_stage(4);
    for (int j = 0; j < 6; j++) begin
      check("en_hold_stage", 32'(stage), 32'd4);
      check("en_hold_busy", 32'(busy), 32'd1);
      en = pat[j];
      @(negedge clk);
    end
    en = 1'b1;
    check("en_done", 32'(done), 32'd1);
    check("en_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // stop and start together mid stage 2: stop wins
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_stage(2);
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_stage", 32'(stage), 32'd0);
    check("ss_done", 32'(done), 32'd0);
    check("ss_adv", 32'(stage_adv), 32'd0);
    @(negedge clk);
    check("ss_dout", 32'(dout), 32'd0);
    check("ss_busy_hold", 32'(busy), 32'd0);
    // start alone from IDLE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rs_stage", 32'(stage), 32'd0);
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_adv", 32'(stage_adv), 32'd0);
    // restart from stage 3: adv pulses
    wait_stage(3);
    start = 1'b1;
    @(negedge clk);
    check("rs3_stage", 32'(stage), 32'd0);
    check("rs3_adv", 32'(stage_adv), 32'd1);
    check("rs3_busy", 32'(busy), 32'd1);
    // restart while already at stage 0: no adv, start beats end of dwell
    @(negedge clk);
    start = 1'b0;
    check("rs0_stage", 32'(stage), 32'd0);
    check("rs0_adv", 32'(stage_adv), 32'd0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("rs_stop_busy", 32'(busy), 32'd0);

    // Dwell 0 acts as 1; out-of-range write ignored
    cfg_write(1, 0, 'h5);
    cfg_write(5, 7, 'hC);
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
    run_seq(9, 1'b1);

    // Asynchronous reset mid stage 3
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_stage(3);
    check("pre_rst_dout", 32'(dout), 32'h9);
    #2 rst = 1'b1;
    #1;
    check("arst_stage", 32'(stage), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dout", 32'(dout), 32'd0);
    check("arst_adv", 32'(stage_adv), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Tables back to defaults: every dwell 1, every word 0
    tb_dout = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    run_seq(5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
